// File: rtl/button_evt_pkg.sv
// Shared state encodings and default timing for the button event decoder.
// Optional feature macro: BUTTON_DOUBLE_CLICK_EN (enables the WAIT2 state).
package button_evt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2,
        ST_WAIT2     = 2'd3
    } btn_state_e;

    localparam int DEF_LONG_PRESS_CYCLES = 50;
    localparam int DEF_REPEAT_CYCLES     = 10;
    localparam int DEF_DBL_WINDOW_CYCLES = 20;
    localparam int DEF_CNT_BITS          = 20;

endpackage

// File: rtl/btn_edge_detect.sv
// Previous-level register with rise/fall decode; reset loads the live level so a
// button held through reset does not look like a fresh press.
module btn_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = level;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= level;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into registered press/release/short/long/repeat pulses.
// Optional feature macro: BUTTON_DOUBLE_CLICK_EN (adds WAIT2 and the double_click pulse).
module button_event_decoder
    import button_evt_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES,
    parameter int DBL_WINDOW_CYCLES = DEF_DBL_WINDOW_CYCLES,
    parameter int CNT_BITS          = DEF_CNT_BITS
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held,
    output logic double_click
);

    localparam logic [CNT_BITS-1:0] LONG_LAST = CNT_BITS'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] REP_LAST  = CNT_BITS'(REPEAT_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] DBL_LAST  = CNT_BITS'(DBL_WINDOW_CYCLES - 1);

    logic rise;
    logic fall;

    btn_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .level (btn_level),
        .rise  (rise),
        .fall  (fall)
    );

    btn_state_e          state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic btn_press_q,    btn_press_d;
    logic btn_release_q,  btn_release_d;
    logic short_press_q,  short_press_d;
    logic long_press_q,   long_press_d;
    logic repeat_pulse_q, repeat_pulse_d;
    logic held_q,         held_d;
    logic double_click_q, double_click_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        btn_press_d    = 1'b0;
        btn_release_d  = 1'b0;
        short_press_d  = 1'b0;
        long_press_d   = 1'b0;
        repeat_pulse_d = 1'b0;
        double_click_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    btn_press_d = 1'b1;
                    state_d     = ST_PRESSED;
                    cnt_d       = '0;
                end
            end
            ST_PRESSED: begin
                // Release takes priority over the long threshold in the same cycle.
                if (fall) begin
                    btn_release_d = 1'b1;
                    short_press_d = 1'b1;
`ifdef BUTTON_DOUBLE_CLICK_EN
                    state_d       = ST_WAIT2;
`else
                    state_d       = ST_IDLE;
`endif
                    cnt_d         = '0;
                end else if (cnt_q == LONG_LAST) begin
                    long_press_d = 1'b1;
                    state_d      = ST_LONG_HELD;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (fall) begin
                    btn_release_d = 1'b1;
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                end else if (cnt_q == REP_LAST) begin
                    repeat_pulse_d = 1'b1;
                    cnt_d          = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT2: begin
                // A rise on the last window cycle still counts as a double click.
`ifdef BUTTON_DOUBLE_CLICK_EN
                if (rise) begin
                    btn_press_d    = 1'b1;
                    double_click_d = 1'b1;
                    state_d        = ST_PRESSED;
                    cnt_d          = '0;
                end else
`endif
                if (cnt_q == DBL_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG_HELD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            btn_press_q    <= 1'b0;
            btn_release_q  <= 1'b0;
            short_press_q  <= 1'b0;
            long_press_q   <= 1'b0;
            repeat_pulse_q <= 1'b0;
            held_q         <= 1'b0;
            double_click_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            btn_press_q    <= btn_press_d;
            btn_release_q  <= btn_release_d;
            short_press_q  <= short_press_d;
            long_press_q   <= long_press_d;
            repeat_pulse_q <= repeat_pulse_d;
            held_q         <= held_d;
            double_click_q <= double_click_d;
        end
    end

    assign btn_press    = btn_press_q;
    assign btn_release  = btn_release_q;
    assign short_press  = short_press_q;
    assign long_press   = long_press_q;
    assign repeat_pulse = repeat_pulse_q;
    assign held         = held_q;
    assign double_click = double_click_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder; double-click steps adapt to BUTTON_DOUBLE_CLICK_EN.
module tb_button_event_decoder;
    import button_evt_pkg::*;

    localparam logic [6:0] B_PRESS = 7'b1000000;
    localparam logic [6:0] B_REL   = 7'b0100000;
    localparam logic [6:0] B_SHORT = 7'b0010000;
    localparam logic [6:0] B_LONG  = 7'b0001000;
    localparam logic [6:0] B_REP   = 7'b0000100;
    localparam logic [6:0] B_HELD  = 7'b0000010;
`ifdef BUTTON_DOUBLE_CLICK_EN
    localparam logic [6:0] B_DBL   = 7'b0000001;
`else
    localparam logic [6:0] B_DBL   = 7'b0000000;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_level = 1'b1;
    logic btn_press, btn_release, short_press, long_press, repeat_pulse, held, double_click;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    button_event_decoder #(
        .LONG_PRESS_CYCLES (DEF_LONG_PRESS_CYCLES),
        .REPEAT_CYCLES     (DEF_REPEAT_CYCLES),
        .DBL_WINDOW_CYCLES (DEF_DBL_WINDOW_CYCLES),
        .CNT_BITS          (DEF_CNT_BITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .btn_release  (btn_release),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .double_click (double_click)
    );

    // One clock edge, then compare all outputs {press,rel,short,long,rep,held,dbl}.
    task automatic tick(input logic [6:0] exp, input string tag);
        logic [6:0] obs;
        @(posedge clk);
        #1;
        obs = {btn_press, btn_release, short_press, long_press, repeat_pulse, held, double_click};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic run(input int n, input logic [6:0] exp, input string tag);
        for (int i = 0; i < n; i++) tick(exp, tag);
    endtask

    initial begin
        // 1: held through reset, released 30 cycles later: silence
        reset = 1'b1; btn_level = 1'b1;
        run(3, 7'b0, "reset_state");
        reset = 1'b0;
        run(30, 7'b0, "held_through_reset");
        btn_level = 1'b0;
        run(5, 7'b0, "release_after_reset");

        // 2: short press, 10 cycles
        btn_level = 1'b1;
        tick(B_PRESS | B_HELD, "short_press_edge");
        run(9, B_HELD, "short_holding");
        btn_level = 1'b0;
        tick(B_REL | B_SHORT, "short_release");
        run(25, 7'b0, "short_idle");

        // 3: hold 85 cycles -> long + 3 repeats
        btn_level = 1'b1;
        tick(B_PRESS | B_HELD, "long_press_edge");
        run(49, B_HELD, "long_pre");
        tick(B_LONG | B_HELD, "long_threshold");
        for (int r = 0; r < 3; r++) begin
            run(9, B_HELD, "long_between_rep");
            tick(B_REP | B_HELD, "repeat_pulse");
        end
        run(4, B_HELD, "long_tail");
        btn_level = 1'b0;
        tick(B_REL, "long_release");
        run(25, 7'b0, "long_idle");

        // 4: fall coincides with long threshold: release wins
        btn_level = 1'b1;
        tick(B_PRESS | B_HELD, "bound_press");
        run(49, B_HELD, "bound_hold");
        btn_level = 1'b0;
        tick(B_REL | B_SHORT, "bound_release_wins");
        run(25, 7'b0, "bound_idle");

        // 5: double click inside window, outside window, and on last window cycle
        btn_level = 1'b1;
        tick(B_PRESS | B_HELD, "dbl_first_press");
        run(4, B_HELD, "dbl_first_hold");
        btn_level = 1'b0;
        tick(B_REL | B_SHORT, "dbl_first_release");
        run(7, 7'b0, "dbl_gap8");
        btn_level = 1'b1;
        tick(B_PRESS | B_HELD | B_DBL, "dbl_second_press");
        run(4, B_HELD, "dbl_second_hold");
        btn_level = 1'b0;
        tick(B_REL | B_SHORT, "dbl_second_release");
        run(24, 7'b0, "dbl_gap25");
        btn_level = 1'b1;
        tick(B_PRESS | B_HELD, "dbl_late_press");
        run(4, B_HELD, "dbl_late_hold");
        btn_level = 1'b0;
        tick(B_REL | B_SHORT, "dbl_late_release");
        run(19, 7'b0, "dbl_gap20");
        btn_level = 1'b1;
        tick(B_PRESS | B_HELD | B_DBL, "dbl_edge_window");
        run(3, B_HELD, "dbl_edge_hold");
        btn_level = 1'b0;
        tick(B_REL | B_SHORT, "dbl_edge_release");
        run(25, 7'b0, "dbl_idle");

        // 6: reset in LONG_HELD abandons state silently
        btn_level = 1'b1;
        tick(B_PRESS | B_HELD, "rst_press");
        run(49, B_HELD, "rst_pre");
        tick(B_LONG | B_HELD, "rst_long");
        run(3, B_HELD, "rst_long_held");
        reset = 1'b1;
        tick(7'b0, "rst_clears_outputs");
        reset = 1'b0;
        run(5, 7'b0, "rst_after_held");
        btn_level = 1'b0;
        run(5, 7'b0, "rst_no_release");
        btn_level = 1'b1;
        tick(B_PRESS | B_HELD, "rst_new_press");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
